// File: rtl/mse_pkg.sv
// Purpose: shared state encoding and datapath widths for the MSE metric block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Difference of two 16-bit signed values never overflows 17 bits.
    localparam int DIFF_W = 17;
    // |diff| <= 65535, so its square fits in 32 unsigned bits.
    localparam int SQ_W   = 32;
    localparam int MSE_W  = 32;

    // Cycles spent in DRAIN: one per pipeline stage still holding the last sample.
    localparam int DRAIN_CYC = 3;

endpackage

// File: rtl/mse_sq_pipe.sv
// Purpose: two-stage error pipeline, S1 = diff, S2 = square and |diff|, with a valid shift.
// Latency: 2 cycles from in_vld to sq_vld.
// Backpressure: none; every valid beat is consumed, and the downstream accumulator always accepts.
//
// Ports:
//   clk, rstN           clock, async active-low reset
//   in_vld              sample pair present this cycle
//   y_exact, y_approx   16-bit signed filter outputs
//   sq_vld              S2 outputs valid
//   sq_dat              diff^2, 32-bit unsigned
//   abs_dat             |diff|, 17-bit unsigned
module mse_sq_pipe
    import mse_pkg::*;
(
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     in_vld,
    input  logic signed [15:0]       y_exact,
    input  logic signed [15:0]       y_approx,
    output logic                     sq_vld,
    output logic [SQ_W-1:0]          sq_dat,
    output logic [DIFF_W-1:0]        abs_dat
);

    logic                     diff_vld;
    logic signed [DIFF_W-1:0] diff_q;
    logic signed [DIFF_W-1:0] diff_c;
    logic [DIFF_W-1:0]        abs_c;
    logic [SQ_W-1:0]          sq_c;

    // Sign-extend both operands by one bit so the subtraction cannot overflow.
    assign diff_c = {y_exact[15], y_exact} - {y_approx[15], y_approx};

    // |diff| is at most 65535, so negating the most negative diff still fits.
    assign abs_c = diff_q[DIFF_W-1] ? $unsigned(-diff_q) : $unsigned(diff_q);

    // Squaring the magnitude keeps the multiply unsigned and 16x16; bit 16 of
    // |diff| is always zero.
    assign sq_c = {16'b0, abs_c[15:0]} * {16'b0, abs_c[15:0]};

    // S1: difference register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            diff_vld <= 1'b0;
            diff_q   <= '0;
        end else begin
            diff_vld <= in_vld;
            if (in_vld) begin
                diff_q <= diff_c;
            end
        end
    end

    // S2: square and magnitude registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sq_vld  <= 1'b0;
            sq_dat  <= '0;
            abs_dat <= '0;
        end else begin
            sq_vld <= diff_vld;
            if (diff_vld) begin
                sq_dat  <= sq_c;
                abs_dat <= abs_c;
            end
        end
    end

endmodule

// File: rtl/mse_metric.sv
// Purpose: accumulate squared error of approximate vs exact FIR over 2^LOG2_N samples; report MSE and peak |error|.
// Latency: done pulses in the 4th cycle after the edge that accepts the last sample of a window.
// Backpressure: none; in_valid samples are taken unconditionally while RUN and ignored in IDLE and DRAIN.
//
// Ports:
//   clk, rstN           clock, async active-low reset
//   start               begin a window (IDLE only)
//   in_valid            y_exact/y_approx pair valid (RUN only)
//   y_exact, y_approx   16-bit signed filter outputs
//   busy                high in RUN or DRAIN
//   done                one-cycle pulse when mse/max_abs_err update
//   mse                 sum of squares >> LOG2_N, held
//   max_abs_err         peak |y_exact - y_approx| of last window, held
module mse_metric
    import mse_pkg::*;
#(
    parameter int LOG2_N = 10,
    parameter int ACC_W  = 48
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic signed [15:0]   y_exact,
    input  logic signed [15:0]   y_approx,
    output logic                 busy,
    output logic                 done,
    output logic [MSE_W-1:0]     mse,
    output logic [DIFF_W-1:0]    max_abs_err
);

    state_t              state_q;
    state_t              state_d;
    logic [LOG2_N-1:0]   cnt_q;
    logic [1:0]          drain_q;
    logic                accept;
    logic                last_acc;
    logic                drain_end;
    logic                win_start;

    logic                sq_vld;
    logic [SQ_W-1:0]     sq_dat;
    logic [DIFF_W-1:0]   abs_dat;

    logic [ACC_W-1:0]    acc_q;
    logic [DIFF_W-1:0]   max_q;

    assign win_start = (state_q == IDLE) && start;
    assign accept    = (state_q == RUN) && in_valid;
    // The counter wraps back to zero on the final accept, so all-ones marks
    // the last sample of the window.
    assign last_acc  = accept && (&cnt_q);
    assign drain_end = (state_q == DRAIN) && (drain_q == 2'(DRAIN_CYC - 1));

    assign busy = (state_q != IDLE);

    // Only accepted beats enter the pipeline, so stray in_valid in IDLE or
    // DRAIN never reaches the accumulator.
    mse_sq_pipe u_sq_pipe (
        .clk      (clk),
        .rstN     (rstN),
        .in_vld   (accept),
        .y_exact  (y_exact),
        .y_approx (y_approx),
        .sq_vld   (sq_vld),
        .sq_dat   (sq_dat),
        .abs_dat  (abs_dat)
    );

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)     state_d = RUN;
            RUN:     if (last_acc)  state_d = DRAIN;
            DRAIN:   if (drain_end) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Sample and drain counters
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt_q   <= '0;
            drain_q <= '0;
        end else begin
            if (win_start) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + LOG2_N'(1);
            end

            if ((state_q != DRAIN) || drain_end) begin
                drain_q <= '0;
            end else begin
                drain_q <= drain_q + 2'd1;
            end
        end
    end

    // ---------------------------------------------------------------
    // S3: accumulator and running max
    // ---------------------------------------------------------------
    // Clearing on start is safe: in IDLE the pipeline has fully drained, so
    // no valid beat can collide with the clear.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            acc_q <= '0;
            max_q <= '0;
        end else if (win_start) begin
            acc_q <= '0;
            max_q <= '0;
        end else if (sq_vld) begin
            acc_q <= acc_q + ACC_W'(sq_dat);
            if (abs_dat > max_q) begin
                max_q <= abs_dat;
            end
        end
    end

    // ---------------------------------------------------------------
    // Result registers
    // ---------------------------------------------------------------
    // By the last DRAIN cycle the final sample has been folded into acc_q.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            done        <= 1'b0;
            mse         <= '0;
            max_abs_err <= '0;
        end else begin
            done <= drain_end;
            if (drain_end) begin
                mse         <= MSE_W'(acc_q >> LOG2_N);
                max_abs_err <= max_q;
            end
        end
    end

endmodule

// File: tb/tb_mse_metric.sv
module tb_mse_metric;

    localparam int LOG2_N = 3;
    localparam int N      = 1 << LOG2_N;

    logic               clk = 1'b0;
    logic               rstN;
    logic               start;
    logic               in_valid;
    logic signed [15:0] y_exact;
    logic signed [15:0] y_approx;
    logic               busy;
    logic               done;
    logic [31:0]        mse;
    logic [16:0]        max_abs_err;

    int n_chk  = 0;
    int n_pass = 0;

    logic signed [15:0] ex [N];
    logic signed [15:0] ap [N];
    longint             prev_mse;
    longint             prev_max;
    logic               seen;

    mse_metric #(.LOG2_N(LOG2_N), .ACC_W(48)) dut (
        .clk         (clk),
        .rstN        (rstN),
        .start       (start),
        .in_valid    (in_valid),
        .y_exact     (y_exact),
        .y_approx    (y_approx),
        .busy        (busy),
        .done        (done),
        .mse         (mse),
        .max_abs_err (max_abs_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: mean of squared differences over the window, and peak magnitude.
    task automatic model(output longint e_mse, output longint e_max);
        longint sse;
        longint d;
        sse   = 0;
        e_max = 0;
        for (int k = 0; k < N; k++) begin
            d   = longint'(ex[k]) - longint'(ap[k]);
            sse += d * d;
            if (d < 0) d = -d;
            if (d > e_max) e_max = d;
        end
        e_mse = sse / N;
    endtask

    task automatic fill(input int e, input int a);
        for (int k = 0; k < N; k++) begin
            ex[k] = 16'(e);
            ap[k] = 16'(a);
        end
    endtask

    // gap_mode: 0 back-to-back, 1 every other cycle, 2 random gaps.
    // idle_cyc: IDLE cycles afterwards with nonzero-diff in_valid noise.
    task automatic run_window(input string tag, input int gap_mode, input int idle_cyc);
        longint e_mse;
        longint e_max;
        int     lat;
        int     gaps;
        model(e_mse, e_max);

        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "/busy_rise"}, busy, 1);
        chk({tag, "/done_one_cycle"}, done, 0);
        chk({tag, "/mse_held"}, mse, prev_mse);

        for (int k = 0; k < N; k++) begin
            gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 3));
            repeat (gaps) begin
                in_valid = 1'b0;
                y_exact  = 16'($urandom);
                y_approx = 16'($urandom);
                start    = 1'($urandom_range(0, 1));
                step();
            end
            start    = 1'b0;
            in_valid = 1'b1;
            y_exact  = ex[k];
            y_approx = ap[k];
            step();
        end

        // Drain: random in_valid must be ignored.
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            y_exact  = 16'($urandom);
            y_approx = 16'($urandom);
            step();
            if (done) begin
                lat = c;
                break;
            end
            chk({tag, "/busy_drain"}, busy, 1);
        end
        in_valid = 1'b0;
        chk({tag, "/done_latency"}, lat, 3);
        chk({tag, "/busy_fall"}, busy, 0);
        chk({tag, "/mse"}, mse, e_mse);
        chk({tag, "/max_abs_err"}, max_abs_err, e_max);
        prev_mse = e_mse;
        prev_max = e_max;

        repeat (idle_cyc) begin
            in_valid = 1'b1;
            y_exact  = 16'sd500;
            y_approx = -16'sd500;
            step();
        end
        in_valid = 1'b0;
        if (idle_cyc > 0) begin
            chk({tag, "/idle_ignores_valid"}, busy, 0);
            chk({tag, "/idle_mse_held"}, mse, e_mse);
        end
    endtask

    initial begin
        rstN     = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        y_exact  = '0;
        y_approx = '0;
        prev_mse = 0;
        prev_max = 0;
        seen     = 1'b0;

        repeat (2) step();
        chk("reset/busy", busy, 0);
        chk("reset/done", done, 0);
        chk("reset/mse", mse, 0);
        chk("reset/max", max_abs_err, 0);
        rstN = 1'b1;
        step();

        fill(1234, 1234);
        run_window("equal", 0, 3);

        fill(100, 97);
        run_window("diff3", 0, 0);   // next start coincides with done cycle

        for (int k = 0; k < N; k++) begin
            ex[k] = 16'(k + 1);
            ap[k] = 16'sd0;
        end
        run_window("ramp", 0, 1);
        run_window("ramp_gap", 1, 2);

        fill(32767, -32768);
        run_window("extreme", 0, 1);

        for (int w = 0; w < 20; w++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            for (int k = 0; k < N; k++) begin
                ap[k] = 16'($urandom);
                case (mode)
                    0: ex[k] = 16'($urandom);
                    1: ex[k] = ap[k] + 16'(int'($urandom_range(0, 64)) - 32);
                    default: begin
                        ex[k] = $urandom_range(0, 1) ? 16'sh7fff : 16'sh8000;
                        ap[k] = $urandom_range(0, 1) ? 16'sh7fff : 16'sh8000;
                    end
                endcase
            end
            run_window("random", 2, int'($urandom_range(0, 3)));
        end

        fill(100, 97);
        run_window("pre_reset", 0, 1);

        // Abort a window halfway with an asynchronous reset.
        fill(50, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            y_exact  = ex[k];
            y_approx = ap[k];
            step();
        end
        in_valid = 1'b0;
        #2 rstN = 1'b0;
        #1;
        chk("abort/busy", busy, 0);
        chk("abort/done", done, 0);
        chk("abort/mse", mse, 0);
        chk("abort/max", max_abs_err, 0);
        step();
        step();
        rstN = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            step();
            seen = seen | done;
        end
        chk("abort/no_done", seen, 0);
        chk("abort/still_idle", busy, 0);
        prev_mse = 0;
        prev_max = 0;

        fill(2, 0);
        run_window("after_abort", 0, 0);

        step();
        chk("final/done_low", done, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
